uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte-buffering front end that sits directly upstream of uart_tx.
- Accepts bursts of bytes from a host-side write port into a synchronous FIFO.
- Drains the FIFO one byte at a time into uart_tx through its enable/busy handshake, so the host never has to poll tx_busy.
- Instantiated beside uart_tx in top levels and loopback benches.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous active-low reset.
- wr_d_i  in  8  byte to enqueue.
- wr_e_i  in  1  enqueue strobe; one byte per cycle while high.
- full_o  out  1  FIFO holds DEPTH bytes.
- empty_o  out  1  FIFO holds 0 bytes.
- level_o  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow_o  out  1  one-cycle pulse when a write is dropped because the FIFO is full.
- tx_d_o  out  8  byte presented to uart_tx d_i.
- tx_e_o  out  1  one-cycle start strobe to uart_tx e_i.
- tx_busy_i  in  1  uart_tx busy_o.

Behaviour:
- Reset is sampled on the clk edge while resetn=0. All state clears:
  - pointers=0, level_o=0, empty_o=1, full_o=0, overflow_o=0
  - tx_e_o=0, tx_d_o=8'h00, FSM=IDLE
  - FIFO memory contents are don't-care.
- Reset mid-transfer: buffered bytes are discarded. tx_e_o is guaranteed low from the first reset cycle. uart_tx is reset by the same resetn, so no partial-frame recovery is attempted.
- Write side:
  - wr_e_i=1 and not full: store wr_d_i at wr_ptr, wr_ptr wraps modulo DEPTH, level+1.
  - wr_e_i=1 and full: data dropped, overflow_o=1 for the next cycle, pointers and level unchanged.
- Read side FSM (states IDLE, ISSUE, WAIT_START, WAIT_DONE):
  - IDLE: if !empty and !tx_busy_i, go to ISSUE. Register tx_d_o <= mem[rd_ptr], advance rd_ptr modulo DEPTH, level-1.
  - ISSUE: tx_e_o=1 for exactly this cycle, with tx_d_o stable. Next state is WAIT_START.
  - WAIT_START: wait until tx_busy_i=1, then go to WAIT_DONE. tx_busy_i is also accepted if it was already high in the ISSUE cycle.
  - WAIT_DONE: wait until tx_busy_i=0, then return to IDLE.
  - tx_d_o holds its value from ISSUE until the next ISSUE.
- Latency:
  - Write into an empty FIFO with uart_tx idle: tx_e_o asserts 2 cycles after the wr_e_i cycle (write at edge N, IDLE pop at N+1, ISSUE at N+2).
  - Back-to-back frames: minimum gap of 2 cycles after busy falls (IDLE, then ISSUE).
- Simultaneous write and pop in the same cycle:
  - level unchanged; both pointers advance.
  - Allowed when full: the pop frees a slot, so the write is accepted and overflow_o stays 0.
  - Allowed when empty: no pop is possible, so the write simply lands.
- full_o, empty_o and level_o are registered. They reflect the post-edge occupancy.
- Width rules:
  - level_o is ADDR_W+1 bits so DEPTH is representable.
  - Pointers are ADDR_W bits and wrap naturally.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state typedef/localparams (IDLE=2'd0, ISSUE=2'd1, WAIT_START=2'd2, WAIT_DONE=2'd3)
  - the UART_DATA_W=8 constant.
- One natural sub-module: sync_fifo_8 (storage, pointers, level, full/empty, overflow). It is reusable later for an RX-side buffer after uart_rx.
- The handshake FSM lives in uart_tx_fifo itself.

Test Plan:
- Reset: hold resetn=0 for 3 cycles while wr_e_i=1 and wr_d_i=8'hA5 -> level_o=0, empty_o=1, tx_e_o=0, overflow_o=0 throughout and after release.
- Single byte: write 8'h55 into an idle block with tx_busy_i=0 -> tx_e_o high exactly one cycle, 2 cycles later, with tx_d_o=8'h55; level_o returns to 0.
- Ordering with uart_tx attached (CLKS_PER_BIT=9) and a uart_rx monitor:
  - burst-write 8'h01, 8'h02, 8'h03 on consecutive cycles
  - -> uart_rx reports 01, 02, 03 in order
  - -> exactly three tx_e_o pulses, each while tx_busy_i=0.
- Full/overflow (DEPTH=16, tx_busy_i forced 1):
  - write 17 bytes 8'h10..8'h20 -> full_o=1 after the 16th; overflow_o pulses once on the 17th; level_o=16.
  - release busy -> 8'h10..8'h1F emitted, and 8'h20 never appears.
- Simultaneous push/pop at full: with full_o=1, write 8'hEE in the IDLE pop cycle -> accepted, overflow_o=0, level_o stays 16, and 8'hEE is emitted last.
- Reset mid-frame: assert resetn=0 while in WAIT_DONE with 5 bytes queued -> FIFO empties; after release, no tx_e_o until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the TX front-end handshake states.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo_8.sv
// Byte-wide synchronous FIFO with registered occupancy flags and overflow pulse.
module sync_fifo_8
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [UART_DATA_W-1:0] wr_d_i,
  input  logic                   wr_e_i,
  input  logic                   rd_e_i,
  output logic [UART_DATA_W-1:0] rd_d_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [ADDR_W:0]        level_o,
  output logic                   overflow_o
);

  logic [UART_DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]      r_wr_ptr;
  logic [ADDR_W-1:0]      r_rd_ptr;
  logic [ADDR_W:0]        r_level;
  logic                   r_full;
  logic                   r_empty;
  logic                   r_overflow;

  logic                   w_push;
  logic                   w_pop;
  logic [ADDR_W:0]        w_level_nxt;

  // A pop in the same cycle frees a slot, so a write at full is still accepted.
  always_comb begin
    w_pop       = rd_e_i & ~r_empty;
    w_push      = wr_e_i & (~r_full | w_pop);
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + (ADDR_W+1)'(1);
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      r_level    <= w_level_nxt;
      r_full     <= (w_level_nxt == (ADDR_W+1)'(DEPTH));
      r_empty    <= (w_level_nxt == '0);
      r_overflow <= wr_e_i & ~w_push;
    end
  end

  assign rd_d_o     = r_mem[r_rd_ptr];
  assign full_o     = r_full;
  assign empty_o    = r_empty;
  assign level_o    = r_level;
  assign overflow_o = r_overflow;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers host bytes and feeds uart_tx one frame at a time via its enable/busy handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [UART_DATA_W-1:0] wr_d_i,
  input  logic                   wr_e_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [ADDR_W:0]        level_o,
  output logic                   overflow_o,
  output logic [UART_DATA_W-1:0] tx_d_o,
  output logic                   tx_e_o,
  input  logic                   tx_busy_i
);

  tx_state_e              r_state;
  tx_state_e              w_state_nxt;
  logic [UART_DATA_W-1:0] r_tx_d;
  logic [UART_DATA_W-1:0] w_fifo_d;
  logic                   w_empty;
  logic                   w_pop;

  sync_fifo_8 #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .wr_d_i     (wr_d_i),
    .wr_e_i     (wr_e_i),
    .rd_e_i     (w_pop),
    .rd_d_o     (w_fifo_d),
    .full_o     (full_o),
    .empty_o    (w_empty),
    .level_o    (level_o),
    .overflow_o (overflow_o)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty && !tx_busy_i) begin
          w_pop       = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      // uart_tx may already report busy in the strobe cycle; skip WAIT_START then.
      ISSUE:      w_state_nxt = tx_busy_i ? WAIT_DONE : WAIT_START;
      WAIT_START: if (tx_busy_i)  w_state_nxt = WAIT_DONE;
      WAIT_DONE:  if (!tx_busy_i) w_state_nxt = IDLE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_tx_d  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_tx_d <= w_fifo_d;
      end
    end
  end

  assign empty_o = w_empty;
  assign tx_d_o  = r_tx_d;
  // Gated by resetn so no start strobe escapes in the first reset cycle.
  assign tx_e_o  = (r_state == ISSUE) & resetn;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural uart_tx busy model (CLKS_PER_BIT=9).
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH        = 16;
  localparam int unsigned CLKS_PER_BIT = 9;
  localparam int unsigned FRAME_CYC    = 10 * CLKS_PER_BIT;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] wr_d = 8'h00;
  logic       wr_e = 1'b0;
  logic       force_busy = 1'b0;
  logic       full, empty, overflow, tx_e;
  logic [4:0] level;
  logic [7:0] tx_d;
  logic       tx_busy;

  int unsigned busy_cnt = 0;
  int          checks = 0;
  int          passes = 0;
  int          long_pulses = 0;
  logic        prev_tx_e = 1'b0;
  logic [7:0]  exp_q [$];
  logic [7:0]  obs_q [$];
  logic        obs_busy_q [$];

  uart_tx_fifo #(
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr_d_i     (wr_d),
    .wr_e_i     (wr_e),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level),
    .overflow_o (overflow),
    .tx_d_o     (tx_d),
    .tx_e_o     (tx_e),
    .tx_busy_i  (tx_busy)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy rises the cycle after e_i and stays up for one frame.
  assign tx_busy = force_busy | (busy_cnt != 0);
  always @(posedge clk) begin
    if (!resetn)                       busy_cnt <= 0;
    else if (tx_e && busy_cnt == 0)    busy_cnt <= FRAME_CYC;
    else if (busy_cnt != 0)            busy_cnt <= busy_cnt - 1;
  end

  // Receiver-side record of every start strobe.
  always @(negedge clk) begin
    if (tx_e === 1'b1) begin
      obs_q.push_back(tx_d);
      obs_busy_q.push_back(tx_busy);
      if (prev_tx_e === 1'b1) long_pulses++;
    end
    prev_tx_e = tx_e;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passes);
    $fatal(1, "timeout");
  end

  task automatic wait_obs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (obs_q.size() >= n) break;
      @(negedge clk);
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (tx_busy === 1'b0 && empty === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    wr_e   = 1'b1;
    wr_d   = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({level, empty, full, tx_e, overflow} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0})
        $display("FAIL reset_hold[%0d]: got level=%0d empty=%b full=%b tx_e=%b ovf=%b, want 0 1 0 0 0",
                 i, level, empty, full, tx_e, overflow);
      else passes++;
    end
    resetn = 1'b1;
    wr_e   = 1'b0;
    @(negedge clk);
    checks++;
    if ({level, empty, full, tx_e, overflow, tx_d} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset_release: got level=%0d empty=%b full=%b tx_e=%b ovf=%b tx_d=%h, want 0 1 0 0 0 00",
               level, empty, full, tx_e, overflow, tx_d);
    else passes++;
    repeat (5) @(negedge clk);
    checks++;
    if (obs_q.size() != 0)
      $display("FAIL reset_no_strobe: got %0d strobes, want 0", obs_q.size());
    else passes++;
  endtask

  task automatic test_single_byte;
    bit ok;
    @(negedge clk);
    wr_d = 8'h55;
    wr_e = 1'b1;
    exp_q.push_back(8'h55);
    @(negedge clk);
    wr_e = 1'b0;
    checks++;
    if ({tx_e, level} !== {1'b0, 5'd1})
      $display("FAIL single_cycle1: got tx_e=%b level=%0d, want 0 1", tx_e, level);
    else passes++;
    @(negedge clk);
    checks++;
    if ({tx_e, tx_d, level} !== {1'b1, 8'h55, 5'd0})
      $display("FAIL single_cycle2: got tx_e=%b tx_d=%h level=%0d, want 1 55 0", tx_e, tx_d, level);
    else passes++;
    @(negedge clk);
    checks++;
    if (tx_e !== 1'b0)
      $display("FAIL single_pulse_width: got tx_e=%b, want 0", tx_e);
    else passes++;
    wait_obs(1, 50, ok);
    wait_idle(500, ok);
    checks++;
    if (!ok) $display("FAIL single_idle: got busy=%b empty=%b, want 0 1", tx_busy, empty);
    else passes++;
    while (exp_q.size() != 0) begin
      checks++;
      if (obs_q.size() == 0) begin
        $display("FAIL single_data: got no strobe, want %h", exp_q.pop_front());
      end else begin
        logic [7:0] e, o;
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        void'(obs_busy_q.pop_front());
        if (o !== e) $display("FAIL single_data: got %h want %h", o, e);
        else passes++;
      end
    end
  endtask

  task automatic test_ordering;
    bit ok;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      wr_d = 8'(i);
      wr_e = 1'b1;
      exp_q.push_back(8'(i));
    end
    @(negedge clk);
    wr_e = 1'b0;
    wait_obs(3, 1000, ok);
    wait_idle(500, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() != 3 || long_pulses != 0)
      $display("FAIL order_pulse_count: got %0d strobes (%0d long), want 3 (0 long)", obs_q.size(), long_pulses);
    else passes++;
    while (exp_q.size() != 0) begin
      checks++;
      if (obs_q.size() == 0) begin
        $display("FAIL order_data: got no strobe, want %h", exp_q.pop_front());
      end else begin
        logic [7:0] e, o;
        logic       b;
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        b = obs_busy_q.pop_front();
        if (o !== e || b !== 1'b0)
          $display("FAIL order_data: got %h busy=%b, want %h busy=0", o, b, e);
        else passes++;
      end
    end
    obs_q.delete();
    obs_busy_q.delete();
  endtask

  task automatic test_overflow_push_pop;
    bit ok;
    @(negedge clk);
    force_busy = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i == 16) begin
        checks++;
        if ({full, level} !== {1'b1, 5'd16})
          $display("FAIL full_after_16: got full=%b level=%0d, want 1 16", full, level);
        else passes++;
      end
      wr_d = 8'h10 + 8'(i);
      wr_e = 1'b1;
      if (i < 16) exp_q.push_back(8'h10 + 8'(i));
    end
    @(negedge clk);
    wr_e = 1'b0;
    checks++;
    if ({overflow, full, level} !== {1'b1, 1'b1, 5'd16})
      $display("FAIL overflow_pulse: got ovf=%b full=%b level=%0d, want 1 1 16", overflow, full, level);
    else passes++;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0)
      $display("FAIL overflow_single: got ovf=%b, want 0", overflow);
    else passes++;
    // Release busy in the same cycle as a write: pop and push coincide at full.
    force_busy = 1'b0;
    wr_d = 8'hEE;
    wr_e = 1'b1;
    exp_q.push_back(8'hEE);
    @(negedge clk);
    wr_e = 1'b0;
    checks++;
    if ({overflow, full, level} !== {1'b0, 1'b1, 5'd16})
      $display("FAIL pushpop_full: got ovf=%b full=%b level=%0d, want 0 1 16", overflow, full, level);
    else passes++;
    wait_obs(17, 3000, ok);
    wait_idle(500, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() != 17)
      $display("FAIL drain_count: got %0d strobes, want 17", obs_q.size());
    else passes++;
    while (exp_q.size() != 0) begin
      checks++;
      if (obs_q.size() == 0) begin
        $display("FAIL drain_data: got no strobe, want %h", exp_q.pop_front());
      end else begin
        logic [7:0] e, o;
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        void'(obs_busy_q.pop_front());
        if (o !== e) $display("FAIL drain_data: got %h want %h", o, e);
        else passes++;
      end
    end
    obs_q.delete();
    obs_busy_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr_d = 8'hA0 + 8'(i);
      wr_e = 1'b1;
      if (i == 0) exp_q.push_back(8'hA0);
    end
    @(negedge clk);
    wr_e = 1'b0;
    checks++;
    if ({level, tx_busy} !== {5'd5, 1'b1})
      $display("FAIL midframe_queued: got level=%0d busy=%b, want 5 1", level, tx_busy);
    else passes++;
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({level, empty, full, tx_e} !== {5'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL midframe_reset: got level=%0d empty=%b full=%b tx_e=%b, want 0 1 0 0",
               level, empty, full, tx_e);
    else passes++;
    @(negedge clk);
    resetn = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (obs_q.size() != 1 || tx_e !== 1'b0)
      $display("FAIL midframe_no_strobe: got %0d strobes tx_e=%b, want 1 0", obs_q.size(), tx_e);
    else passes++;
    @(negedge clk);
    wr_d = 8'h77;
    wr_e = 1'b1;
    exp_q.push_back(8'h77);
    @(negedge clk);
    wr_e = 1'b0;
    wait_obs(2, 100, ok);
    wait_idle(500, ok);
    while (exp_q.size() != 0) begin
      checks++;
      if (obs_q.size() == 0) begin
        $display("FAIL midframe_data: got no strobe, want %h", exp_q.pop_front());
      end else begin
        logic [7:0] e, o;
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        void'(obs_busy_q.pop_front());
        if (o !== e) $display("FAIL midframe_data: got %h want %h", o, e);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0)
      $display("FAIL midframe_extra: got %0d extra strobes, want 0", obs_q.size());
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_ordering();
    test_overflow_push_pop();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
